modulo_mux_varredura: RTL and testbench
=======================================

# modulo_mux_varredura

Parametrised, registered N-channel, W-bit multiplexer with an automatic scan mode. It extends the fixed 4:1 single-bit combinational selector into a clocked channel scanner. In manual mode it follows an external select; in scan mode it steps through all channels at a programmable rate. It drives time-multiplexed displays and LED matrices, and provides the registered per-channel one-hot enables those loads need.

## Interface
- `WIDTH`, 1: bits per channel.
- `CHANNELS`, 4: number of input channels; must be ≥ 2.
- `SEL_W`, 2: select width; must satisfy 2^SEL_W ≥ CHANNELS.
- `DIVIDER`, 50000: clock cycles per channel in scan mode; must be ≥ 2.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `data_in`  in  CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `mode`  in  1: 0 = manual (follow `input_sel`), 1 = automatic scan.
- `input_sel`  in  SEL_W: channel request in manual mode.
- `hold`  in  1: freezes the channel register and the prescaler in both modes.
- `out`  out  WIDTH: registered selected channel data.
- `chan_sel`  out  SEL_W: current channel register.
- `chan_onehot`  out  CHANNELS: registered one-hot enable of the channel driving `out`.
- `tick`  out  1: one-cycle pulse when scan advances the channel.

## Operation
- State register `st` ∈ {MANUAL, SCAN, BLANK}. It takes MANUAL or SCAN directly from `mode`, except while in BLANK.
- Channel register `chan` is SEL_W bits. Prescaler `pcnt` counts 0..DIVIDER-1.
- MANUAL:
  - If `hold`=0 and `input_sel` < CHANNELS, `chan` ← `input_sel`.
  - If `input_sel` ≥ CHANNELS, `chan` keeps its previous value.
  - `pcnt` is held at 0 and `tick` = 0.
- SCAN, `hold`=0:
  - `pcnt` increments each cycle.
  - When `pcnt` = DIVIDER-1: `pcnt` ← 0, `chan` ← `chan`+1, wrapping CHANNELS-1 → 0, and `tick` = 1 on that same edge.
- `hold`=1 in either mode: `chan` and `pcnt` are frozen and `tick` = 0. `out` and `chan_onehot` keep tracking the frozen `chan`, so `data_in` changes are still followed.
- MANUAL → SCAN transition: `pcnt` restarts at 0 and `chan` continues from its current value. SCAN → MANUAL: `pcnt` is cleared.
- Output path, every cycle:
  - `out` ← `data_in`[chan*WIDTH +: WIDTH].
  - `chan_onehot` ← 1 << chan.
  - `chan_sel` is `chan` directly.
- Reset has priority over all other inputs. It sets:
  - `chan`=0, `pcnt`=0, `st`=MANUAL;
  - `out`=0, `chan_onehot`=0, `tick`=0.
- Reset asserted mid-scan aborts the count. After release, `st` is taken from `mode` on the first edge.

## Timing
- Latency: `out` and `chan_onehot` at edge t+1 reflect `chan` and `data_in` sampled at edge t, i.e. one cycle.
- Manual select: a change on `input_sel` sampled at edge t appears on `chan_sel` after edge t and on `out` after edge t+1.
- Scan period: each channel is held for exactly DIVIDER cycles; a full frame is CHANNELS*DIVIDER cycles.
- `tick` is registered and coincides with the first cycle the new `chan_sel` is visible.
- `hold` sampled at edge t suppresses the advance at edge t, including when `pcnt` = DIVIDER-1. The advance then occurs on the first edge with `hold`=0.
- First cycle after reset release: `chan_onehot` = 0. The next cycle it becomes 1 (channel 0).

## Configuration
- Macro: `MUX_VARREDURA_BLANK_EN`.
- Defined:
  - Whenever `chan` changes, in either mode, `st` enters BLANK for exactly one cycle.
  - During BLANK, `out` and `chan_onehot` are registered as all zeros.
  - The new channel appears on the following cycle, so the output latency after a switch is 2 cycles.
  - Prescaler counting continues through BLANK, so the scan period is unchanged.
  - BLANK returns to MANUAL or SCAN according to `mode`.
  - This suppresses ghosting on multiplexed displays.
- Undefined: the BLANK state and its logic are not compiled; outputs switch directly with 1-cycle latency.

## Test plan
- Reset → all outputs 0. WIDTH=4, CHANNELS=4, mode=0, `data_in`=16'hDCBA, `input_sel`=2: `out`=4'hC and `chan_onehot`=4'b0100 two cycles after reset release.
- CHANNELS=3, manual, `input_sel` = 1 then 3 → `chan_sel` stays 1, `out` keeps channel 1 data.
- Scan, DIVIDER=4, CHANNELS=4:
  - `tick` pulses every 4 cycles;
  - `chan_sel` runs 0,1,2,3,0;
  - `chan_onehot` runs 0001→0010→0100→1000→0001, each lagging `chan_sel` by one cycle.
- Scan with `hold`=1 asserted at `pcnt`=3 for 5 cycles → no `tick` and no advance. Advance on the first edge after `hold` drops.
- `reset` pulsed for one cycle mid-scan with `chan`=2 → next cycle `chan_sel`=0, `out`=0, `chan_onehot`=0. Scan then restarts with a full DIVIDER period.
- With `MUX_VARREDURA_BLANK_EN`, manual switch 0→1 → one cycle of `out`=0 and `chan_onehot`=0, then channel 1 data with `chan_onehot`=0010.

Source files
------------

// File: rtl/modulo_mux_varredura_if.sv
// modulo_mux_varredura_if: channel data, control and scan outputs
// of the registered channel scanner, grouped with master/slave views.
interface modulo_mux_varredura_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic                      mode;
  logic [SEL_W-1:0]          input_sel;
  logic                      hold;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          chan_sel;
  logic [CHANNELS-1:0]       chan_onehot;
  logic                      tick;

  modport master (
    output data_in,
    output mode,
    output input_sel,
    output hold,
    input  out,
    input  chan_sel,
    input  chan_onehot,
    input  tick
  );

  modport slave (
    input  data_in,
    input  mode,
    input  input_sel,
    input  hold,
    output out,
    output chan_sel,
    output chan_onehot,
    output tick
  );
endinterface

// File: rtl/modulo_mux_varredura.sv
// modulo_mux_varredura: registered N:1 channel mux with scan mode.
// Optional one-cycle blanking on channel switch: MUX_VARREDURA_BLANK_EN.
module modulo_mux_varredura #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DIVIDER  = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  modulo_mux_varredura_if.slave   bus
);

  localparam int PW = $clog2(DIVIDER);
  localparam logic [PW-1:0]    PLAST = PW'(DIVIDER - 1);
  localparam logic [SEL_W-1:0] CLAST = SEL_W'(CHANNELS - 1);

`ifdef MUX_VARREDURA_BLANK_EN
  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    BLANK  = 2'd2
  } st_t;
`else
  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1
  } st_t;
`endif

  st_t                 st_q, st_d;
  logic [SEL_W-1:0]    chan_q, chan_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [CHANNELS-1:0] oh_q, oh_d;
  logic                tick_q, tick_d;

  logic [WIDTH-1:0]    data_sel;
  logic [CHANNELS-1:0] oh_sel;
  logic [PW-1:0]       pcnt_base;
  logic [SEL_W-1:0]    chan_inc;
  logic                sel_ok;
  logic                scan_run;
  logic                scan_hold;
  logic                man_load;

  // Data and one-hot enable of the current channel register.
  always_comb begin
    data_sel = '0;
    oh_sel   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (chan_q == SEL_W'(k)) begin
        data_sel  = bus.data_in[k*WIDTH +: WIDTH];
        oh_sel[k] = 1'b1;
      end
    end
  end

  // Next channel, prescaler, tick, state and output values.
  always_comb begin
    sel_ok    = (int'(bus.input_sel) < CHANNELS);
    scan_run  = bus.mode && !bus.hold;
    scan_hold = bus.mode && bus.hold;
    man_load  = !bus.mode && !bus.hold && sel_ok;
    // Entering scan from manual always restarts the count.
    pcnt_base = (st_q == MANUAL) ? '0 : pcnt_q;
    chan_inc  = (chan_q == CLAST) ? '0 : chan_q + SEL_W'(1);

    chan_d = chan_q;
    pcnt_d = '0;
    tick_d = 1'b0;

    unique case (1'b1)
      scan_run: begin
        if (pcnt_base == PLAST) begin
          chan_d = chan_inc;
          tick_d = 1'b1;
        end else begin
          pcnt_d = pcnt_base + PW'(1);
        end
      end
      scan_hold: pcnt_d = pcnt_base;
      man_load:  chan_d = bus.input_sel;
      default:   ;
    endcase

`ifdef MUX_VARREDURA_BLANK_EN
    if (chan_d != chan_q) begin
      st_d = BLANK;
    end else begin
      st_d = bus.mode ? SCAN : MANUAL;
    end
    out_d = (st_q == BLANK) ? '0 : data_sel;
    oh_d  = (st_q == BLANK) ? '0 : oh_sel;
`else
    st_d  = bus.mode ? SCAN : MANUAL;
    out_d = data_sel;
    oh_d  = oh_sel;
`endif
  end

  // State, channel, prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= MANUAL;
      chan_q <= '0;
      pcnt_q <= '0;
      out_q  <= '0;
      oh_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      chan_q <= chan_d;
      pcnt_q <= pcnt_d;
      out_q  <= out_d;
      oh_q   <= oh_d;
      tick_q <= tick_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.chan_sel    = chan_q;
  assign bus.chan_onehot = oh_q;
  assign bus.tick        = tick_q;

endmodule

// File: tb/tb_modulo_mux_varredura.sv
// tb_modulo_mux_varredura: directed stimulus, queued expectations,
// negedge monitor comparing registered outputs of two configurations.
module tb_modulo_mux_varredura;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    int          cyc;
    int          id;
    string       nm;
    logic [3:0]  o;
    logic [1:0]  s;
    logic [3:0]  oh;
    logic        t;
  } exp_t;

  exp_t q[$];

  modulo_mux_varredura_if #(
    .WIDTH(4), .CHANNELS(4), .SEL_W(2)
  ) bus_a ();

  modulo_mux_varredura_if #(
    .WIDTH(4), .CHANNELS(3), .SEL_W(2)
  ) bus_b ();

  modulo_mux_varredura #(
    .WIDTH(4), .CHANNELS(4), .SEL_W(2), .DIVIDER(4)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  modulo_mux_varredura #(
    .WIDTH(4), .CHANNELS(3), .SEL_W(2), .DIVIDER(4)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due this cycle and compares.
  initial begin
    exp_t       e;
    logic [3:0] ao;
    logic [1:0] as;
    logic [3:0] aoh;
    logic       at;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.id == 0) begin
          ao  = bus_a.out;
          as  = bus_a.chan_sel;
          aoh = bus_a.chan_onehot;
          at  = bus_a.tick;
        end else begin
          ao  = bus_b.out;
          as  = bus_b.chan_sel;
          aoh = {1'b0, bus_b.chan_onehot};
          at  = bus_b.tick;
        end
        n_cmp++;
        if (e.cyc != cyc || ao !== e.o || as !== e.s ||
            aoh !== e.oh || at !== e.t) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got out=%h sel=%0d oh=%b tick=%b, want out=%h sel=%0d oh=%b tick=%b (due %0d)",
                   e.nm, cyc, ao, as, aoh, at,
                   e.o, e.s, e.oh, e.t, e.cyc);
        end
      end
    end
  end

  task automatic sa(input bit r, input bit m,
                    input logic [1:0] s, input bit h,
                    input logic [3:0] eo, input logic [1:0] es,
                    input logic [3:0] eoh, input bit et,
                    input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = r;
    bus_a.mode      = m;
    bus_a.input_sel = s;
    bus_a.hold      = h;
    e.cyc = cyc + 1;
    e.id  = 0;
    e.nm  = nm;
    e.o   = eo;
    e.s   = es;
    e.oh  = eoh;
    e.t   = et;
    q.push_back(e);
  endtask

  task automatic sb(input bit m, input logic [1:0] s,
                    input logic [3:0] eo, input logic [1:0] es,
                    input logic [2:0] eoh, input bit et,
                    input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bus_b.mode      = m;
    bus_b.input_sel = s;
    bus_b.hold      = 1'b0;
    e.cyc = cyc + 1;
    e.id  = 1;
    e.nm  = nm;
    e.o   = eo;
    e.s   = es;
    e.oh  = {1'b0, eoh};
    e.t   = et;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc             = 0;
    n_cmp           = 0;
    n_bad           = 0;
    reset           = 1'b1;
    bus_a.data_in   = 16'hDCBA;
    bus_a.mode      = 1'b0;
    bus_a.input_sel = 2'd2;
    bus_a.hold      = 1'b0;
    bus_b.data_in   = 12'hCBA;
    bus_b.mode      = 1'b0;
    bus_b.input_sel = 2'd0;
    bus_b.hold      = 1'b0;
    repeat (2) @(posedge clk);

`ifdef MUX_VARREDURA_BLANK_EN
    sa(1, 0, 0, 0, 4'h0, 0, 4'b0000, 0, "b_reset");
    sa(0, 0, 0, 0, 4'hA, 0, 4'b0001, 0, "b_ch0");
    sa(0, 0, 1, 0, 4'hA, 1, 4'b0001, 0, "b_sw");
    sa(0, 0, 1, 0, 4'h0, 1, 4'b0000, 0, "b_blank");
    sa(0, 0, 1, 0, 4'hB, 1, 4'b0010, 0, "b_ch1");
    for (int i = 0; i < 3; i++)
      sa(0, 1, 1, 0, 4'hB, 1, 4'b0010, 0, "b_scan");
    sa(0, 1, 1, 0, 4'hB, 2, 4'b0010, 1, "b_tick");
    sa(0, 1, 1, 0, 4'h0, 2, 4'b0000, 0, "b_sblank");
    sa(0, 1, 1, 0, 4'hC, 2, 4'b0100, 0, "b_ch2");
`else
    sa(1, 0, 2, 0, 4'h0, 0, 4'b0000, 0, "reset");
    sa(0, 0, 2, 0, 4'hA, 2, 4'b0001, 0, "release");
    sa(0, 0, 2, 0, 4'hC, 2, 4'b0100, 0, "man2");
    sa(0, 0, 3, 0, 4'hC, 3, 4'b0100, 0, "man3");
    sa(0, 0, 1, 1, 4'hD, 3, 4'b1000, 0, "man_hold");
    sa(0, 0, 1, 0, 4'hD, 1, 4'b1000, 0, "man1");
    sa(0, 0, 1, 0, 4'hB, 1, 4'b0010, 0, "man1_out");
    sa(0, 0, 0, 0, 4'hB, 0, 4'b0010, 0, "man0");
    for (int i = 0; i < 3; i++)
      sa(0, 1, 0, 0, 4'hA, 0, 4'b0001, 0, "scan0");
    sa(0, 1, 0, 0, 4'hA, 1, 4'b0001, 1, "tick1");
    for (int i = 0; i < 3; i++)
      sa(0, 1, 0, 0, 4'hB, 1, 4'b0010, 0, "scan1");
    sa(0, 1, 0, 0, 4'hB, 2, 4'b0010, 1, "tick2");
    for (int i = 0; i < 3; i++)
      sa(0, 1, 0, 0, 4'hC, 2, 4'b0100, 0, "scan2");
    sa(0, 1, 0, 0, 4'hC, 3, 4'b0100, 1, "tick3");
    for (int i = 0; i < 3; i++)
      sa(0, 1, 0, 0, 4'hD, 3, 4'b1000, 0, "scan3");
    sa(0, 1, 0, 0, 4'hD, 0, 4'b1000, 1, "tick_wrap");
    for (int i = 0; i < 3; i++)
      sa(0, 1, 0, 0, 4'hA, 0, 4'b0001, 0, "scan0b");
    for (int i = 0; i < 5; i++)
      sa(0, 1, 0, 1, 4'hA, 0, 4'b0001, 0, "scan_hold");
    sa(0, 1, 0, 0, 4'hA, 1, 4'b0001, 1, "unhold");
    for (int i = 0; i < 3; i++)
      sa(0, 1, 0, 0, 4'hB, 1, 4'b0010, 0, "scan1b");
    sa(0, 1, 0, 0, 4'hB, 2, 4'b0010, 1, "tick2b");
    for (int i = 0; i < 2; i++)
      sa(0, 1, 0, 0, 4'hC, 2, 4'b0100, 0, "scan2b");
    sa(1, 1, 0, 0, 4'h0, 0, 4'b0000, 0, "mid_reset");
    for (int i = 0; i < 3; i++)
      sa(0, 1, 0, 0, 4'hA, 0, 4'b0001, 0, "rescan0");
    sa(0, 1, 0, 0, 4'hA, 1, 4'b0001, 1, "retick1");
    sa(0, 0, 3, 0, 4'hB, 3, 4'b0010, 0, "to_manual");
    sa(0, 0, 3, 0, 4'hD, 3, 4'b1000, 0, "manual3");

    sb(0, 1, 4'hA, 1, 3'b001, 0, "c3_sel1");
    sb(0, 3, 4'hB, 1, 3'b010, 0, "c3_sel3");
    sb(0, 3, 4'hB, 1, 3'b010, 0, "c3_keep");
    sb(0, 2, 4'hB, 2, 3'b010, 0, "c3_sel2");
    sb(0, 2, 4'hC, 2, 3'b100, 0, "c3_out2");
    for (int i = 0; i < 3; i++)
      sb(1, 0, 4'hC, 2, 3'b100, 0, "c3_scan2");
    sb(1, 0, 4'hC, 0, 3'b100, 1, "c3_wrap");
    sb(1, 0, 4'hA, 0, 3'b001, 0, "c3_out0");
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
